// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: sequencer for the shared iterative multiply/divide unit.
// Operands are converted to magnitudes on accept, iterated one bit per cycle
// (shift-add multiply, restoring divide), and the sign fix-up is applied while
// the DONE cycle presents the result. Divide-by-zero and signed overflow skip
// the iteration and go straight to DONE.
module muldiv_seq_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic            mul_en_i,
  input  logic            rs1_sign_i,
  input  logic            rs2_sign_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            out_valid_o,
  output logic [XLEN-1:0] result_1_o,
  output logic [XLEN-1:0] result_2_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  count_r;
  logic [XLEN-1:0]   hi_r;        // mul: upper accumulator; div: partial remainder
  logic [XLEN-1:0]   lo_r;        // mul: multiplier/low product; div: dividend/quotient
  logic [XLEN-1:0]   opb_r;       // mul: multiplicand; div: divisor
  logic              mul_r;
  logic              neg_q_r;     // negate product / quotient in DONE
  logic              neg_r_r;     // negate remainder in DONE
  logic [XLEN-1:0]   result_1_r;
  logic [XLEN-1:0]   result_2_r;

  // Conditional two's complement of one XLEN word.
  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    if (n) begin
      r = ~v + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Conditional two's complement of a double-width product.
  function automatic logic [2*XLEN-1:0] neg_if2(input logic n, input logic [2*XLEN-1:0] v);
    logic [2*XLEN-1:0] r;
    if (n) begin
      r = ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic              neg1_s, neg2_s;
  logic [XLEN-1:0]   abs1_s, abs2_s;
  logic              div_zero_s, ovf_s, special_s, accept_s, last_iter_s;
  logic [XLEN:0]     mul_sum_s, div_shift_s, div_trial_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fix_1_s, fix_2_s;

  assign neg1_s      = rs1_sign_i & rs1_data_i[XLEN-1];
  assign neg2_s      = rs2_sign_i & rs2_data_i[XLEN-1];
  assign abs1_s      = neg_if(neg1_s, rs1_data_i);
  assign abs2_s      = neg_if(neg2_s, rs2_data_i);
  assign div_zero_s  = ~mul_en_i & (rs2_data_i == {XLEN{1'b0}});
  assign ovf_s       = ~mul_en_i & rs1_sign_i & rs2_sign_i
                     & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                     & (rs2_data_i == {XLEN{1'b1}});
  assign special_s   = div_zero_s | ovf_s;
  assign accept_s    = (state_r == ST_IDLE) & req_valid_i & ~flush_i;
  assign last_iter_s = (count_r == CNT_W'(XLEN-1));

  // One iteration step: add-then-shift for multiply, trial subtract for divide.
  assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
  assign div_shift_s = {hi_r, lo_r[XLEN-1]};
  assign div_trial_s = div_shift_s - {1'b0, opb_r};

  // Sign fix-up of the finished magnitudes, presented during DONE.
  assign prod_s  = neg_if2(neg_q_r, {hi_r, lo_r});
  assign fix_1_s = mul_r ? prod_s[XLEN-1:0]      : neg_if(neg_q_r, lo_r);
  assign fix_2_s = mul_r ? prod_s[2*XLEN-1:XLEN] : neg_if(neg_r_r, hi_r);

  // A flush arriving in DONE suppresses the pulse, so the new result is only
  // shown when the pulse is actually delivered; otherwise the last one is held.
  assign out_valid_o = (state_r == ST_DONE) & ~flush_i;
  assign stall_o     = req_valid_i & ~out_valid_o;
  assign result_1_o  = out_valid_o ? fix_1_s : result_1_r;
  assign result_2_o  = out_valid_o ? fix_2_s : result_2_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (special_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          state_nxt_s = ST_IDLE;
        end else if (last_iter_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= {CNT_W{1'b0}};
      hi_r       <= {XLEN{1'b0}};
      lo_r       <= {XLEN{1'b0}};
      opb_r      <= {XLEN{1'b0}};
      mul_r      <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      result_1_r <= {XLEN{1'b0}};
      result_2_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            count_r <= {CNT_W{1'b0}};
            mul_r   <= mul_en_i;
            opb_r   <= mul_en_i ? abs1_s : abs2_s;
            if (mul_en_i) begin
              hi_r    <= {XLEN{1'b0}};
              lo_r    <= abs2_s;
              neg_q_r <= neg1_s ^ neg2_s;
              neg_r_r <= 1'b0;
            end else if (div_zero_s) begin
              hi_r    <= rs1_data_i;
              lo_r    <= {XLEN{1'b1}};
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
            end else if (ovf_s) begin
              hi_r    <= {XLEN{1'b0}};
              lo_r    <= rs1_data_i;
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
            end else begin
              hi_r    <= {XLEN{1'b0}};
              lo_r    <= abs1_s;
              neg_q_r <= neg1_s ^ neg2_s;
              neg_r_r <= neg1_s;
            end
          end
        end
        ST_CALC: begin
          count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (mul_r) begin
            hi_r <= mul_sum_s[XLEN:1];
            lo_r <= {mul_sum_s[0], lo_r[XLEN-1:1]};
          end else if (!div_trial_s[XLEN]) begin
            hi_r <= div_trial_s[XLEN-1:0];
            lo_r <= {lo_r[XLEN-2:0], 1'b1};
          end else begin
            hi_r <= div_shift_s[XLEN-1:0];
            lo_r <= {lo_r[XLEN-2:0], 1'b0};
          end
        end
        ST_DONE: begin
          if (!flush_i) begin
            result_1_r <= fix_1_s;
            result_2_r <= fix_2_s;
          end
        end
        default: begin
          count_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed self-checking bench for muldiv_seq_ctrl (XLEN=64).
// Inputs change and outputs are sampled just after the falling edge.
module tb_muldiv_seq_ctrl;
  localparam int XLEN = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, mul_en, rs1_sign, rs2_sign, flush;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            stall, out_valid;
  logic [XLEN-1:0] result_1, result_2;

  int total = 0;
  int bad   = 0;
  logic [63:0] prev1 = 64'h0;
  logic [63:0] prev2 = 64'h0;

  always #5 clk = ~clk;

  muldiv_seq_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .mul_en_i(mul_en),
    .rs1_sign_i(rs1_sign), .rs2_sign_i(rs2_sign), .rs1_data_i(rs1_data),
    .rs2_data_i(rs2_data), .flush_i(flush), .stall_o(stall),
    .out_valid_o(out_valid), .result_1_o(result_1), .result_2_o(result_2)
  );

  // Runs one request starting in the current cycle (caller is at a falling edge).
  task automatic do_op(input logic mul, input logic s1, input logic s2,
                       input logic [63:0] a, input logic [63:0] b, input int lat,
                       input logic [63:0] e1, input logic [63:0] e2, input string nm);
    int   cyc = -1;
    int   stall_n = 0;
    logic seen = 1'b0;
    req_valid = 1'b1; mul_en = mul; rs1_sign = s1; rs2_sign = s2;
    rs1_data = a; rs2_data = b;
    for (int c = 0; c < 100 && !seen; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        cyc  = c;
      end else begin
        if (stall === 1'b1) stall_n++;
        if (c == 1) begin
          total++;
          if (result_1 !== prev1 || result_2 !== prev2) begin
            bad++;
            $display("FAIL %s_hold: got %h/%h want %h/%h", nm, result_1, result_2, prev1, prev2);
          end
          rs1_data = ~a; rs2_data = ~b;
        end
        @(negedge clk);
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: no out_valid within 100 cycles", nm);
    end else begin
      total++;
      if (cyc != lat) begin
        bad++;
        $display("FAIL %s_latency: got %0d want %0d", nm, cyc, lat);
      end
      total++;
      if (result_1 !== e1) begin
        bad++;
        $display("FAIL %s_result_1: got %h want %h", nm, result_1, e1);
      end
      total++;
      if (result_2 !== e2) begin
        bad++;
        $display("FAIL %s_result_2: got %h want %h", nm, result_2, e2);
      end
      total++;
      if (stall !== 1'b0 || stall_n != lat) begin
        bad++;
        $display("FAIL %s_stall: got stall=%b cycles=%0d want stall=0 cycles=%0d", nm, stall, stall_n, lat);
      end
    end
    prev1 = e1; prev2 = e2;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || result_1 !== e1 || result_2 !== e2) begin
      bad++;
      $display("FAIL %s_after: got ov=%b %h/%h want ov=0 %h/%h", nm, out_valid, result_1, result_2, e1, e2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; mul_en = 1'b0; rs1_sign = 1'b0; rs2_sign = 1'b0;
    flush = 1'b0; rs1_data = 64'h0; rs2_data = 64'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || stall !== 1'b0 || result_1 !== 64'h0 || result_2 !== 64'h0) begin
      bad++;
      $display("FAIL reset: got ov=%b st=%b %h/%h want all zero", out_valid, stall, result_1, result_2);
    end
  endtask

  task automatic test_mul();
    @(negedge clk);
    do_op(1'b1, 1'b1, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65, 64'hFFFF_FFFF_FFFF_FFEB, ONES, "mul_s");
    @(negedge clk);
    do_op(1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, ONES, 65, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mulhsu");
  endtask

  task automatic test_div();
    @(negedge clk);
    do_op(1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 65, 64'd14, 64'd2, "divu");
    @(negedge clk);
    do_op(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, ONES, "div_neg_dvd");
    @(negedge clk);
    do_op(1'b0, 1'b1, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, "div_neg_dvs");
  endtask

  task automatic test_special();
    @(negedge clk);
    do_op(1'b0, 1'b0, 1'b0, 64'd5, 64'd0, 1, ONES, 64'd5, "divu_zero");
    @(negedge clk);
    do_op(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1, ONES, 64'hFFFF_FFFF_FFFF_FFFB, "div_zero_s");
    @(negedge clk);
    do_op(1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0000, ONES, 1, 64'h8000_0000_0000_0000, 64'd0, "div_ovf");
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 1'b0, 1'b0, ONES, 64'h10, 65, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, "b2b_divu");
    do_op(1'b1, 1'b0, 1'b0, 64'd3, 64'd5, 65, 64'd15, 64'd0, "b2b_mulu");
  endtask

  task automatic test_flush();
    logic ov_seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; mul_en = 1'b1; rs1_sign = 1'b0; rs2_sign = 1'b0;
    rs1_data = ONES; rs2_data = ONES;
    for (int c = 0; c <= 10; c++) begin
      #1;
      if (out_valid === 1'b1) ov_seen = 1'b1;
      if (c == 10) flush = 1'b1;
      @(negedge clk);
    end
    flush = 1'b0;
    #1;
    total++;
    if (ov_seen || out_valid !== 1'b0 || result_1 !== prev1 || result_2 !== prev2) begin
      bad++;
      $display("FAIL flush_calc: got ov=%b/%b %h/%h want ov=0 %h/%h", ov_seen, out_valid, result_1, result_2, prev1, prev2);
    end
    do_op(1'b1, 1'b0, 1'b0, ONES, ONES, 65, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, "after_flush");
    // Flush in IDLE must block acceptance of a would-be special case.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; mul_en = 1'b0; rs1_data = 64'd9; rs2_data = 64'd0;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result_1 !== prev1) begin
      bad++;
      $display("FAIL flush_idle: got ov=%b r1=%h want ov=0 r1=%h", out_valid, result_1, prev1);
    end
    // Flush during DONE suppresses the pulse and keeps old results.
    @(negedge clk);
    req_valid = 1'b1; rs1_data = 64'd9; rs2_data = 64'd0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || result_1 !== prev1 || result_2 !== prev2) begin
      bad++;
      $display("FAIL flush_done: got ov=%b %h/%h want ov=0 %h/%h", out_valid, result_1, result_2, prev1, prev2);
    end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result_1 !== prev1 || result_2 !== prev2) begin
      bad++;
      $display("FAIL flush_done_hold: got ov=%b %h/%h want ov=0 %h/%h", out_valid, result_1, result_2, prev1, prev2);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic ov_seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; mul_en = 1'b1; rs1_sign = 1'b0; rs2_sign = 1'b0;
    rs1_data = 64'd3; rs2_data = 64'd5;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || stall !== 1'b0 || result_1 !== 64'h0 || result_2 !== 64'h0) begin
      bad++;
      $display("FAIL reset_mid: got ov=%b st=%b %h/%h want all zero", out_valid, stall, result_1, result_2);
    end
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) ov_seen = 1'b1;
    end
    total++;
    if (ov_seen) begin
      bad++;
      $display("FAIL reset_mid_discard: got out_valid=1 want 0");
    end
    prev1 = 64'h0; prev2 = 64'h0;
    @(negedge clk);
    do_op(1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 65, 64'd14, 64'd2, "post_reset");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
